rtc_lector_bus: RTL and testbench

Periodic reader for the RTC chip's multiplexed 8-bit address/data bus. On each sweep request it issues the chip's transfer command, reads the eleven time/date/timer registers in a fixed order, and commits all eleven BCD bytes to its outputs atomically in a single cycle. It is the producing end of the `datos0`..`datos10` inputs that the VGA display interface latches during vertical blanking.

---
 rtl/rtc_bus_pkg.sv | 36 +++
 rtl/rtc_bus_fase.sv | 40 ++++
 rtl/rtc_lector_bus.sv | 148 ++++++++++++++
 tb/tb_rtc_lector_bus.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// rtl/rtc_bus_pkg.sv - shared states, constants and address table for the RTC bus reader
package rtc_bus_pkg;

  typedef enum logic [3:0] {
    IDLE,
    A_SETUP,
    A_STROBE,
    A_HOLD,
    A_GAP,
    D_SETUP,
    D_STROBE,
    D_GAP,
    COMMIT
  } estado_t;

  localparam int          N_REGS       = 11;
  localparam logic [7:0]  CMD_TRANSFER = 8'hF0;
  // Index value reserved for the transfer command that opens every sweep
  localparam logic [3:0]  IDX_CMD      = 4'hF;

  localparam logic [N_REGS-1:0][7:0] ADDR_TABLE = {
    8'h43, 8'h42, 8'h41,
    8'h28, 8'h27, 8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21
  };

  function automatic logic [7:0] dir_bus(input logic [3:0] idx);
    if (idx == IDX_CMD) begin
      return CMD_TRANSFER;
    end else if (idx < 4'(N_REGS)) begin
      return ADDR_TABLE[idx];
    end else begin
      return 8'h00;
    end
  endfunction

endpackage

// File: rtl/rtc_bus_fase.sv
// rtl/rtc_bus_fase.sv - per-phase cycle timer: strobe window, capture point and phase end
module rtc_bus_fase #(
  parameter int T_STROBE = 7,
  parameter int T_GAP    = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic leer,
  output logic wr_en,
  output logic rd_en,
  output logic capture,
  output logic done
);

  localparam int LAST = T_STROBE + T_GAP + 1;
  localparam int CW   = $clog2(LAST + 1);

  logic [CW-1:0] cnt;
  logic          in_strobe;

  // cnt is the cycle index inside the current phase; 0 is the setup cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (!done) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Strobe enables mean "the next cycle is still a strobe cycle"
  assign in_strobe = (cnt < CW'(T_STROBE));
  assign wr_en     = in_strobe && !leer;
  assign rd_en     = in_strobe && leer;
  assign capture   = leer && (cnt == CW'(T_STROBE));
  assign done      = (cnt == CW'(LAST));

endmodule

// File: rtl/rtc_lector_bus.sv
// rtl/rtc_lector_bus.sv - sweeps the RTC registers over the muxed bus and commits them atomically
module rtc_lector_bus
  import rtc_bus_pkg::*;
#(
  parameter int T_STROBE = 7,
  parameter int T_GAP    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic [7:0] datos0,
  output logic [7:0] datos1,
  output logic [7:0] datos2,
  output logic [7:0] datos3,
  output logic [7:0] datos4,
  output logic [7:0] datos5,
  output logic [7:0] datos6,
  output logic [7:0] datos7,
  output logic [7:0] datos8,
  output logic [7:0] datos9,
  output logic [7:0] datos10,
  output logic       ocupado,
  output logic       listo
);

  estado_t                state, state_d;
  logic [3:0]             idx, idx_d;
  logic                   fase_start, leer, drive_d;
  logic                   wr_en, rd_en, capture, done;
  logic [N_REGS-1:0][7:0] shadow, datos_q;

  assign leer = (state == D_SETUP) || (state == D_STROBE) || (state == D_GAP);

  rtc_bus_fase #(
    .T_STROBE (T_STROBE),
    .T_GAP    (T_GAP)
  ) u_fase (
    .clk     (clk),
    .reset   (reset),
    .start   (fase_start),
    .leer    (leer),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .capture (capture),
    .done    (done)
  );

  always_comb begin
    state_d    = state;
    idx_d      = idx;
    fase_start = 1'b0;
    case (state)
      IDLE: begin
        if (iniciar) begin
          state_d    = A_SETUP;
          idx_d      = IDX_CMD;
          fase_start = 1'b1;
        end
      end
      A_SETUP:  state_d = A_STROBE;
      A_STROBE: if (!wr_en) state_d = A_HOLD;
      A_HOLD:   state_d = A_GAP;
      A_GAP: begin
        if (done) begin
          fase_start = 1'b1;
          if (idx == IDX_CMD) begin
            idx_d   = 4'd0;
            state_d = A_SETUP;
          end else begin
            state_d = D_SETUP;
          end
        end
      end
      D_SETUP:  state_d = D_STROBE;
      D_STROBE: if (!rd_en) state_d = D_GAP;
      D_GAP: begin
        if (done) begin
          if (idx == 4'(N_REGS - 1)) begin
            state_d = COMMIT;
          end else begin
            idx_d      = idx + 4'd1;
            state_d    = A_SETUP;
            fase_start = 1'b1;
          end
        end
      end
      COMMIT:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign drive_d = (state_d == A_SETUP) || (state_d == A_STROBE) || (state_d == A_HOLD);

  // Bus pins are registered from the next-state decode so they line up with the state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      idx     <= IDX_CMD;
      cs_n    <= 1'b1;
      rd_n    <= 1'b1;
      wr_n    <= 1'b1;
      a_d     <= 1'b1;
      ad_out  <= 8'h00;
      ad_oe   <= 1'b0;
      ocupado <= 1'b0;
      listo   <= 1'b0;
      shadow  <= '0;
      datos_q <= '0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      cs_n    <= !(drive_d || (state_d == D_SETUP) || (state_d == D_STROBE));
      wr_n    <= (state_d != A_STROBE);
      rd_n    <= (state_d != D_STROBE);
      a_d     <= !(drive_d || (state_d == A_GAP));
      ad_oe   <= drive_d;
      ad_out  <= drive_d ? dir_bus(idx_d) : 8'h00;
      ocupado <= (state_d != IDLE) || (state == COMMIT);
      listo   <= (state == COMMIT);
      if ((state == D_STROBE) && capture) begin
        shadow[idx] <= ad_in;
      end
      if (state == COMMIT) begin
        datos_q <= shadow;
      end
    end
  end

  assign datos0  = datos_q[0];
  assign datos1  = datos_q[1];
  assign datos2  = datos_q[2];
  assign datos3  = datos_q[3];
  assign datos4  = datos_q[4];
  assign datos5  = datos_q[5];
  assign datos6  = datos_q[6];
  assign datos7  = datos_q[7];
  assign datos8  = datos_q[8];
  assign datos9  = datos_q[9];
  assign datos10 = datos_q[10];

endmodule

// File: tb/tb_rtc_lector_bus.sv
// tb/tb_rtc_lector_bus.sv - self-checking bench for rtc_lector_bus
module tb_rtc_lector_bus;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic iniciar = 1'b0, iniciar1 = 1'b0;
  logic [7:0] ad_in, ad_out, ad_in1, ad_out1;
  logic ad_oe, cs_n, rd_n, wr_n, a_d, ocupado, listo;
  logic ad_oe1, cs_n1, rd_n1, wr_n1, a_d1, ocupado1, listo1;
  logic [10:0][7:0] dq, dq1;

  logic [7:0] mask = 8'h55, mask1 = 8'hC3;
  logic [7:0] lat = 8'h00, lat1 = 8'h00;

  // Chip model: remembers the last address written and answers addr ^ mask
  always @(posedge clk) begin
    if (!cs_n && !wr_n) lat <= ad_out;
    if (!cs_n1 && !wr_n1) lat1 <= ad_out1;
  end
  assign ad_in  = lat ^ mask;
  assign ad_in1 = lat1 ^ mask1;

  rtc_lector_bus dut (
    .clk(clk), .reset(reset), .iniciar(iniciar), .ad_in(ad_in), .ad_out(ad_out),
    .ad_oe(ad_oe), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d),
    .datos0(dq[0]), .datos1(dq[1]), .datos2(dq[2]), .datos3(dq[3]), .datos4(dq[4]),
    .datos5(dq[5]), .datos6(dq[6]), .datos7(dq[7]), .datos8(dq[8]), .datos9(dq[9]),
    .datos10(dq[10]), .ocupado(ocupado), .listo(listo)
  );

  rtc_lector_bus #(.T_STROBE(1), .T_GAP(1)) dut1 (
    .clk(clk), .reset(reset), .iniciar(iniciar1), .ad_in(ad_in1), .ad_out(ad_out1),
    .ad_oe(ad_oe1), .cs_n(cs_n1), .rd_n(rd_n1), .wr_n(wr_n1), .a_d(a_d1),
    .datos0(dq1[0]), .datos1(dq1[1]), .datos2(dq1[2]), .datos3(dq1[3]), .datos4(dq1[4]),
    .datos5(dq1[5]), .datos6(dq1[6]), .datos7(dq1[7]), .datos8(dq1[8]), .datos9(dq1[9]),
    .datos10(dq1[10]), .ocupado(ocupado1), .listo(listo1)
  );

  typedef struct {
    int               start;
    int               lat;
    logic [10:0][7:0] exp;
  } sb_t;

  typedef struct {
    logic [7:0]       mask;
    int               lat;
    logic [10:0][7:0] exp;
  } vec_t;

  logic [7:0] tb_addr [11] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28,
                               8'h41, 8'h42, 8'h43};
  logic [7:0] exp_seq [23];
  vec_t       vt [4];
  sb_t        sb [$];
  logic [7:0] ev_log [$];
  int         listo_times [$];

  int n_cmp = 0, n_err = 0, cyc = 0, sb_rd = 0;
  int wr_len = 0, rd_len = 0, bad_proto = 0, glitch = 0;
  int listo_n = 0, listo1_n = 0, listo1_cyc = 0;
  logic [7:0]       wr_addr = 8'h00;
  logic [10:0][7:0] prev_dq = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [10:0][7:0] exp_for(input logic [7:0] m);
    logic [10:0][7:0] r;
    for (int i = 0; i < 11; i++) r[i] = tb_addr[i] ^ m;
    return r;
  endfunction

  task automatic push_exp(input int start, input logic [10:0][7:0] e);
    sb_t r;
    r.start = start;
    r.lat   = 277;
    r.exp   = e;
    sb.push_back(r);
  endtask

  // One clock: advance to the falling edge and run every bus/commit monitor
  task automatic step();
    @(negedge clk);
    cyc++;
    if (reset) begin
      if (!rd_n && !wr_n) bad_proto++;
      if (!rd_n && ad_oe) bad_proto++;
      if (!wr_n) begin
        wr_len++;
        wr_addr = ad_out;
      end else if (wr_len != 0) begin
        check("wr_strobe_len", wr_len, 7);
        ev_log.push_back(wr_addr);
        wr_len = 0;
      end
      if (!rd_n) begin
        rd_len++;
      end else if (rd_len != 0) begin
        check("rd_strobe_len", rd_len, 7);
        ev_log.push_back(8'h00);
        rd_len = 0;
      end
      if (!listo && (dq !== prev_dq)) glitch++;
      if (listo) begin
        listo_n++;
        listo_times.push_back(cyc);
        check("listo_pending", sb_rd < sb.size(), 1);
        if (sb_rd < sb.size()) begin
          check("latency", cyc - sb[sb_rd].start, sb[sb_rd].lat);
          for (int i = 0; i < 11; i++)
            check($sformatf("datos%0d", i), dq[i], sb[sb_rd].exp[i]);
          sb_rd++;
        end
      end
      if (listo1) begin
        listo1_n++;
        listo1_cyc = cyc;
      end
    end else begin
      wr_len = 0;
      rd_len = 0;
    end
    prev_dq = dq;
  endtask

  task automatic start_sweep(input logic [7:0] m, input logic [10:0][7:0] e, input bit expect_it);
    mask    = m;
    iniciar = 1'b1;
    if (expect_it) push_exp(cyc + 1, e);
    step();
    iniciar = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (((sb_rd < sb.size()) || ocupado) && (n < budget)) begin
      step();
      n++;
    end
    check("sweep_done_in_budget", n < budget, 1);
  endtask

  task automatic check_seq(input int base, input string tag);
    check({tag, "_event_count"}, ev_log.size() - base, 23);
    for (int k = 0; k < 23; k++)
      if (base + k < ev_log.size())
        check($sformatf("%s_event%0d", tag, k), ev_log[base + k], exp_seq[k]);
  endtask

  initial begin
    int base, ln, lt, n, s1;

    exp_seq[0] = 8'hF0;
    for (int i = 0; i < 11; i++) begin
      exp_seq[1 + 2 * i] = tb_addr[i];
      exp_seq[2 + 2 * i] = 8'h00;
    end
    vt[0].mask = 8'h55; vt[1].mask = 8'h00; vt[2].mask = 8'hFF; vt[3].mask = 8'hA3;
    for (int v = 0; v < 4; v++) begin
      vt[v].lat = 277;
      vt[v].exp = exp_for(vt[v].mask);
    end
    vt[0].exp[0]  = 8'h74;
    vt[0].exp[10] = 8'h16;

    repeat (3) step();
    check("rst_cs_n", cs_n, 1);
    check("rst_rd_n", rd_n, 1);
    check("rst_wr_n", wr_n, 1);
    check("rst_a_d", a_d, 1);
    check("rst_ad_out", ad_out, 8'h00);
    check("rst_ad_oe", ad_oe, 0);
    check("rst_ocupado", ocupado, 0);
    check("rst_listo", listo, 0);
    for (int i = 0; i < 11; i++) check($sformatf("rst_datos%0d", i), dq[i], 8'h00);
    reset = 1'b1;
    repeat (3) step();

    for (int v = 0; v < 4; v++) begin
      base = ev_log.size();
      start_sweep(vt[v].mask, vt[v].exp, 1'b1);
      check("ocupado_after_accept", ocupado, 1);
      wait_done(400);
      check_seq(base, "sweep");
      repeat (5) step();
    end

    base = ev_log.size();
    ln   = listo_n;
    start_sweep(8'h5A, exp_for(8'h5A), 1'b1);
    repeat (99) step();
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    wait_done(400);
    repeat (300) step();
    check("busy_listo_count", listo_n - ln, 1);
    check_seq(base, "busy");

    ln   = listo_n;
    lt   = listo_times.size();
    mask = 8'h96;
    iniciar = 1'b1;
    push_exp(cyc + 1, exp_for(8'h96));
    push_exp(cyc + 1 + 278, exp_for(8'h96));
    push_exp(cyc + 1 + 556, exp_for(8'h96));
    repeat (600) step();
    iniciar = 1'b0;
    wait_done(400);
    check("held_listo_count", listo_n - ln, 3);
    if (listo_times.size() >= lt + 2)
      check("held_spacing", listo_times[lt + 1] - listo_times[lt], 278);

    start_sweep(8'h55, exp_for(8'h55), 1'b0);
    repeat (149) step();
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_cs_n", cs_n, 1);
    check("mid_rst_rd_n", rd_n, 1);
    check("mid_rst_wr_n", wr_n, 1);
    check("mid_rst_ad_oe", ad_oe, 0);
    check("mid_rst_ocupado", ocupado, 0);
    for (int i = 0; i < 11; i++) check($sformatf("mid_rst_datos%0d", i), dq[i], 8'h00);
    repeat (3) step();
    reset = 1'b1;
    repeat (3) step();
    base = ev_log.size();
    start_sweep(8'h3C, exp_for(8'h3C), 1'b1);
    wait_done(400);
    check_seq(base, "after_reset");

    ln = listo1_n;
    iniciar1 = 1'b1;
    s1 = cyc + 1;
    step();
    iniciar1 = 1'b0;
    n = 0;
    while ((listo1_n == ln) && (n < 200)) begin
      step();
      n++;
    end
    check("corner_listo_seen", listo1_n - ln, 1);
    check("corner_latency", listo1_cyc - s1, 93);
    for (int i = 0; i < 11; i++)
      check($sformatf("corner_datos%0d", i), dq1[i], tb_addr[i] ^ mask1);

    repeat (5) step();
    check("rd_wr_overlap_or_oe_in_read", bad_proto, 0);
    check("datos_change_without_listo", glitch, 0);
    check("all_expected_listo", sb_rd, sb.size());

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
